// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle, byte-addressable data memory sitting on the memory side of
//   the core's load/store port. One request is taken at a time. The access
//   waits LATENCY cycles and then commits. The result (or an error) is then
//   held on the response channel until the requester takes it.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid and ready are both high. The producer keeps valid and
//   its payload stable until that edge. The consumer's ready may be set
//   freely. req_ready depends only on state, never on rsp_ready.
//
// Parameters
//   ADDR_W   byte-address width, storage is 2**ADDR_W bytes
//   LATENCY  cycles spent in WAIT before the access commits (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  high only in IDLE
//   req_we     1 = store, 0 = load
//   req_fun3   RV32 size/sign code (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   req_addr   byte address
//   req_wdata  store data, low byte/half used for sb/sh
//   rsp_valid  response present (RESP state)
//   rsp_ready  requester accepts response
//   rsp_rdata  extended load data, 0 for stores and errors
//   rsp_err    misaligned or illegal access
//   busy       high whenever not IDLE
//   dbg_state  current FSM state encoding, for checkers
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_fun3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [2:0]          fun3_q, fun3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [7:0]          mem_q [DEPTH];

   logic [ADDR_W-1:0]   a1, a2, a3;
   logic [7:0]          b0, b1, b2, b3;
   logic                acc_err;
   logic [31:0]         acc_rdata;
   logic                commit;
   logic [3:0]          byte_en;

   // Lane addresses. Aligned accesses never cross the top of the array, so
   // the natural wrap of these adders is never used by a legal access.
   assign a1 = addr_q + ADDR_W'(1);
   assign a2 = addr_q + ADDR_W'(2);
   assign a3 = addr_q + ADDR_W'(3);

   assign b0 = mem_q[addr_q];
   assign b1 = mem_q[a1];
   assign b2 = mem_q[a2];
   assign b3 = mem_q[a3];

   assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

   // Access decode: error detection, load extension and store byte enables.
   always_comb begin
      acc_err   = 1'b0;
      acc_rdata = 32'h0;
      byte_en   = 4'b0000;
      case (fun3_q)
         3'b000: begin
            acc_rdata = {{24{b0[7]}}, b0};
            byte_en   = 4'b0001;
         end
         3'b001: begin
            acc_err   = addr_q[0];
            acc_rdata = {{16{b1[7]}}, b1, b0};
            byte_en   = 4'b0011;
         end
         3'b010: begin
            acc_err   = (addr_q[1:0] != 2'b00);
            acc_rdata = {b3, b2, b1, b0};
            byte_en   = 4'b1111;
         end
         3'b100: begin
            acc_err   = we_q;
            acc_rdata = {24'h0, b0};
         end
         3'b101: begin
            acc_err   = we_q | addr_q[0];
            acc_rdata = {16'h0, b1, b0};
         end
         default: acc_err = 1'b1;
      endcase
      // Stores and errors return zero data; errors write nothing.
      if (acc_err || we_q) begin
         acc_rdata = 32'h0;
      end
      if (acc_err || !we_q || !commit) begin
         byte_en = 4'b0000;
      end
   end

   // Storage is deliberately not reset. A reset before the commit edge has
   // already moved state_q out of WAIT, so an aborted store never writes.
   always_ff @(posedge clk) begin
      if (byte_en[0]) mem_q[addr_q] <= wdata_q[7:0];
      if (byte_en[1]) mem_q[a1]     <= wdata_q[15:8];
      if (byte_en[2]) mem_q[a2]     <= wdata_q[23:16];
      if (byte_en[3]) mem_q[a3]     <= wdata_q[31:24];
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      fun3_d  = fun3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               fun3_d  = req_fun3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 4'(LATENCY - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = acc_rdata;
               err_d   = acc_err;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         fun3_q  <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         fun3_q  <= fun3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode straight from the state register, so an async reset
   // drops rsp_valid/busy immediately.
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A byte-array reference model
//   produces the expected {err, rdata} of each request. The result is pushed
//   to exp_q when the request is driven and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int AW  = 8;
   localparam int LAT = 3;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_fun3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic [1:0]    dbg_state;

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   logic [32:0]   exp_q[$];
   logic [7:0]    mem_m [256];
   logic [31:0]   last_rdata;
   logic          last_err;

   dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_fun3  (req_fun3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [32:0] model_access(input logic we, input logic [2:0] f,
                                                input logic [7:0] a, input logic [31:0] wd);
      logic       err;
      logic [7:0] b0, b1, b2, b3;
      logic [31:0] w;
      case (f)
         3'b000:  err = 1'b0;
         3'b001:  err = a[0];
         3'b010:  err = (a[1:0] != 2'b00);
         3'b100:  err = we;
         3'b101:  err = we | a[0];
         default: err = 1'b1;
      endcase
      if (err) return {1'b1, 32'h0};
      if (we) begin
         mem_m[a] = wd[7:0];
         if (f != 3'b000) mem_m[a + 8'd1] = wd[15:8];
         if (f == 3'b010) begin
            mem_m[a + 8'd2] = wd[23:16];
            mem_m[a + 8'd3] = wd[31:24];
         end
         return {1'b0, 32'h0};
      end
      b0 = mem_m[a];
      b1 = mem_m[a + 8'd1];
      b2 = mem_m[a + 8'd2];
      b3 = mem_m[a + 8'd3];
      case (f)
         3'b000:  w = {{24{b0[7]}}, b0};
         3'b001:  w = {{16{b1[7]}}, b1, b0};
         3'b010:  w = {b3, b2, b1, b0};
         3'b100:  w = {24'h0, b0};
         default: w = {16'h0, b1, b0};
      endcase
      return {1'b0, w};
   endfunction

   // ---------------- driver tasks ----------------
   // Drives one request and returns #1 after its accept edge. Request
   // fields are scrambled afterwards; the DUT must ignore them.
   task automatic issue(input logic we, input logic [2:0] f, input logic [7:0] a,
                        input logic [31:0] wd);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_fun3  = f;
      req_addr  = a;
      req_wdata = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!req_ready) begin
         bad++;
         $display("FAIL accept_timeout req_ready=%b want 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_fun3  = 3'($urandom_range(0, 7));
      req_addr  = 8'($urandom_range(0, 255));
      req_wdata = $urandom;
   endtask

   // Waits for the response, pops and compares, then accepts it.
   task automatic collect(input string name);
      int n = 0;
      logic [32:0] e;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!rsp_valid) begin
         bad++;
         $display("FAIL %s rsp_timeout rsp_valid=%b want 1", name, rsp_valid);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      total++;
      if ({rsp_err, rsp_rdata} !== e) begin
         bad++;
         $display("FAIL %s err=%b rdata=%h want err=%b rdata=%h",
                  name, rsp_err, rsp_rdata, e[32], e[31:0]);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic access(input string name, input logic we, input logic [2:0] f,
                         input logic [7:0] a, input logic [31:0] wd);
      exp_q.push_back(model_access(we, f, a, wd));
      issue(we, f, a, wd);
      collect(name);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready, rsp_valid, busy, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_state rdy=%b vld=%b busy=%b err=%b rdata=%h want 1 0 0 0 0",
                  req_ready, rsp_valid, busy, rsp_err, rsp_rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle rdy=%b busy=%b want 1 0", req_ready, busy);
      end
   endtask

   task automatic test_word();
      access("sw_10", 1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
      access("lw_10", 1'b0, 3'b010, 8'h10, 32'h0);
      total++;
      if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
         bad++;
         $display("FAIL lw_10_const rdata=%h err=%b want deadbeef 0", last_rdata, last_err);
      end
      access("lbu_13", 1'b0, 3'b100, 8'h13, 32'h0);
      total++;
      if (last_rdata !== 32'h000000DE) begin
         bad++;
         $display("FAIL lbu_13_const rdata=%h want 000000de", last_rdata);
      end
      access("lb_10", 1'b0, 3'b000, 8'h10, 32'h0);
      total++;
      if (last_rdata !== 32'hFFFFFFEF) begin
         bad++;
         $display("FAIL lb_10_const rdata=%h want ffffffef", last_rdata);
      end
   endtask

   task automatic test_half();
      access("sw_20", 1'b1, 3'b010, 8'h20, 32'h44332211);
      access("sw_24", 1'b1, 3'b010, 8'h24, 32'h88776655);
      access("sh_22", 1'b1, 3'b001, 8'h22, 32'h12348001);
      access("lh_22", 1'b0, 3'b001, 8'h22, 32'h0);
      total++;
      if (last_rdata !== 32'hFFFF8001) begin
         bad++;
         $display("FAIL lh_22_const rdata=%h want ffff8001", last_rdata);
      end
      access("lhu_22", 1'b0, 3'b101, 8'h22, 32'h0);
      total++;
      if (last_rdata !== 32'h00008001) begin
         bad++;
         $display("FAIL lhu_22_const rdata=%h want 00008001", last_rdata);
      end
      access("lw_20", 1'b0, 3'b010, 8'h20, 32'h0);
      total++;
      if (last_rdata !== 32'h80012211) begin
         bad++;
         $display("FAIL lw_20_const rdata=%h want 80012211", last_rdata);
      end
      access("lbu_24", 1'b0, 3'b100, 8'h24, 32'h0);
      total++;
      if (last_rdata !== 32'h00000055) begin
         bad++;
         $display("FAIL lbu_24_const rdata=%h want 00000055", last_rdata);
      end
   endtask

   task automatic test_errors();
      access("lw_11_err", 1'b0, 3'b010, 8'h11, 32'h0);
      access("sh_23_err", 1'b1, 3'b001, 8'h23, 32'hFFFFFFFF);
      access("f011_err", 1'b0, 3'b011, 8'h10, 32'h0);
      access("sw_12_err", 1'b1, 3'b010, 8'h12, 32'h00000000);
      access("sbu_err", 1'b1, 3'b100, 8'h10, 32'h00000000);
      access("shu_err", 1'b1, 3'b101, 8'h10, 32'h00000000);
      access("lhu_odd_err", 1'b0, 3'b101, 8'h11, 32'h0);
      access("f111_err", 1'b1, 3'b111, 8'h10, 32'h0);
      total++;
      if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
         bad++;
         $display("FAIL f111_const err=%b rdata=%h want 1 0", last_err, last_rdata);
      end
      access("lw_10_after_err", 1'b0, 3'b010, 8'h10, 32'h0);
      total++;
      if (last_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL mem_after_err rdata=%h want deadbeef", last_rdata);
      end
      access("lw_20_after_err", 1'b0, 3'b010, 8'h20, 32'h0);
   endtask

   task automatic test_latency();
      int edges = 1;
      logic [32:0] e;
      e = model_access(1'b0, 3'b010, 8'h24, 32'h0);
      exp_q.push_back(e);
      issue(1'b0, 3'b010, 8'h24, 32'h0);
      while (!rsp_valid && edges < 40) begin
         total++;
         if (req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wait_flags rdy=%b busy=%b want 0 1", req_ready, busy);
         end
         @(posedge clk);
         #1;
         edges++;
      end
      total++;
      if (edges !== LAT + 1) begin
         bad++;
         $display("FAIL latency edges=%0d want %0d", edges, LAT + 1);
      end
      rsp_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_err, rsp_rdata} !== e) begin
            bad++;
            $display("FAIL resp_hold vld=%b rdy=%b err=%b rdata=%h want 1 0 %b %h",
                     rsp_valid, req_ready, rsp_err, rsp_rdata, e[32], e[31:0]);
         end
      end
      collect("lat_lw_24");
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_rsp rdy=%b vld=%b busy=%b want 1 0 0",
                  req_ready, rsp_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      int acc_t[$];
      int n = 0;
      logic [32:0] e;
      e = model_access(1'b0, 3'b010, 8'h10, 32'h0);
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_fun3  = 3'b010;
      req_addr  = 8'h10;
      repeat (4 * (LAT + 2)) begin
         if (req_ready) acc_t.push_back(cyc);
         if (rsp_valid) begin
            total++;
            if ({rsp_err, rsp_rdata} !== e) begin
               bad++;
               $display("FAIL b2b_data err=%b rdata=%h want %b %h",
                        rsp_err, rsp_rdata, e[32], e[31:0]);
            end
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      rsp_ready = 1'b0;
      total++;
      if (acc_t.size() < 3) begin
         bad++;
         $display("FAIL b2b_count accepts=%0d want >=3", acc_t.size());
      end
      for (int i = 1; i < acc_t.size(); i++) begin
         total++;
         if (acc_t[i] - acc_t[i-1] !== LAT + 2) begin
            bad++;
            $display("FAIL b2b_spacing gap=%0d want %0d", acc_t[i] - acc_t[i-1], LAT + 2);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         logic [7:0]  a;
         logic [31:0] d;
         a = 8'h40 + 8'($urandom_range(0, 15) * 4);
         d = $urandom;
         access("rnd_sw", 1'b1, 3'b010, a, d);
         access("rnd_lb", 1'b0, 3'b000, a + 8'($urandom_range(0, 3)), 32'h0);
         access("rnd_sh", 1'b1, 3'b001, a + 8'($urandom_range(0, 1) * 2), $urandom);
         access("rnd_lw", 1'b0, 3'b010, a, 32'h0);
      end
   endtask

   task automatic test_reset_mid_wait();
      issue(1'b0, 3'b010, 8'h10, 32'h0);
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_wait_busy busy=%b rdy=%b want 1 0", busy, req_ready);
      end
      #1 rst = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset rdy=%b vld=%b busy=%b want 1 0 0",
                  req_ready, rsp_valid, busy);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_top_boundary();
      access("sb_ff", 1'b1, 3'b000, 8'hFF, 32'h123456AA);
      access("lbu_ff", 1'b0, 3'b100, 8'hFF, 32'h0);
      total++;
      if (last_rdata !== 32'h000000AA) begin
         bad++;
         $display("FAIL lbu_ff_const rdata=%h want 000000aa", last_rdata);
      end
      // Store aborted by reset before commit: no model update, no expectation.
      issue(1'b1, 3'b000, 8'hFF, 32'h00000055);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      access("lbu_ff_abort", 1'b0, 3'b100, 8'hFF, 32'h0);
      total++;
      if (last_rdata !== 32'h000000AA) begin
         bad++;
         $display("FAIL abort_store rdata=%h want 000000aa", last_rdata);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_fun3  = 3'b000;
      req_addr  = '0;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      test_reset();
      test_word();
      test_half();
      test_errors();
      test_latency();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      test_top_boundary();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t want finish earlier", $time);
      $fatal(1);
   end

endmodule
